// File: rtl/tdc_spi_slave_emulator.sv
// SPI mode-1 slave emulating the TDC register interface.
// Oversamples the SPI pins on clk; opcode-first frames, data MSB first.
`timescale 1ns/1ps
module tdc_spi_slave_emulator #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    spi_clk,
    input  logic                    spi_csn,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic                    spi_miso_oe,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    rd_req,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [8*DATA_BYTES-1:0] rd_data,
    output logic                    por_pulse,
    output logic                    init_pulse,
    output logic                    frame_err
);

    localparam int DW = 8 * DATA_BYTES;
    localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);
    localparam logic [7:0] AMASK = 8'((1 << ADDR_W) - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] OPCODE = 3'd1;
    localparam logic [2:0] WDATA  = 3'd2;
    localparam logic [2:0] RDATA  = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;

    logic [2:0]    sclk_s;
    logic [2:0]    csn_s;
    logic [1:0]    mosi_s;
    logic          sclk_rise;
    logic          sclk_fall;
    logic          csn_rise;
    logic          csn_fall;
    logic          mosi_bit;

    logic [2:0]    state;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic          op_done;
    logic          rd_req_d;
    logic [7:0]    opcode_sr;
    logic [DW-2:0] wr_sr;
    logic [DW-1:0] tx_sr;
    logic          is_wr;
    logic          is_rd;
    logic          last_bit;

    // Third flop of each chain is edge history, so events land 3 clk after the pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s <= '0;
            csn_s  <= '0;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], spi_clk};
            csn_s  <= {csn_s[1:0], spi_csn};
            mosi_s <= {mosi_s[0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign csn_rise  = csn_s[1] & ~csn_s[2];
    assign csn_fall  = ~csn_s[1] & csn_s[2];
    assign mosi_bit  = mosi_s[1];

    assign is_wr    = (opcode_sr & ~AMASK) == 8'h80;
    assign is_rd    = (opcode_sr & ~AMASK) == 8'hB0;
    assign last_bit = (bit_cnt == 3'd7) && (byte_cnt == LAST_BYTE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            op_done     <= 1'b0;
            rd_req_d    <= 1'b0;
            opcode_sr   <= '0;
            wr_sr       <= '0;
            tx_sr       <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            por_pulse   <= 1'b0;
            init_pulse  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            rd_req     <= 1'b0;
            por_pulse  <= 1'b0;
            init_pulse <= 1'b0;
            frame_err  <= 1'b0;
            rd_req_d   <= rd_req;
            if (csn_rise) begin
                state       <= IDLE;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                op_done     <= 1'b0;
                bit_cnt     <= '0;
                byte_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (csn_fall) begin
                            state       <= OPCODE;
                            bit_cnt     <= '0;
                            byte_cnt    <= '0;
                            op_done     <= 1'b0;
                            spi_miso_oe <= 1'b1;
                            spi_miso    <= 1'b0;
                        end
                    end
                    OPCODE: begin
                        if (op_done) begin
                            op_done <= 1'b0;
                            unique case (1'b1)
                                is_wr: state <= WDATA;
                                is_rd: begin
                                    rd_req  <= 1'b1;
                                    rd_addr <= opcode_sr[ADDR_W-1:0];
                                    state   <= RDATA;
                                end
                                opcode_sr == 8'h50: begin
                                    por_pulse <= 1'b1;
                                    state     <= DRAIN;
                                end
                                opcode_sr == 8'h70: begin
                                    init_pulse <= 1'b1;
                                    state      <= DRAIN;
                                end
                                default: begin
                                    frame_err <= 1'b1;
                                    state     <= DRAIN;
                                end
                            endcase
                        end else if (sclk_fall) begin
                            opcode_sr <= {opcode_sr[6:0], mosi_bit};
                            bit_cnt   <= bit_cnt + 3'd1;
                            op_done   <= (bit_cnt == 3'd7);
                        end
                    end
                    WDATA: begin
                        if (sclk_fall) begin
                            wr_sr   <= {wr_sr[DW-3:0], mosi_bit};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                wr_en   <= 1'b1;
                                wr_addr <= opcode_sr[ADDR_W-1:0];
                                wr_data <= {wr_sr, mosi_bit};
                                state   <= DRAIN;
                            end else if (bit_cnt == 3'd7) begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                    end
                    RDATA: begin
                        // Register bank answers one clk after seeing rd_req.
                        if (rd_req_d) begin
                            tx_sr <= rd_data;
                        end else if (sclk_rise) begin
                            spi_miso <= tx_sr[DW-1];
                            tx_sr    <= {tx_sr[DW-2:0], 1'b0};
                        end
                        if (sclk_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                spi_miso <= 1'b0;
                                state    <= DRAIN;
                            end else if (bit_cnt == 3'd7) begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                    end
                    DRAIN: spi_miso <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
